// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants and receiver state encoding.
// Imported by crc32_rx and packet_receiver.
package eth_pkg;

  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int HDR_LEN = 14;
  localparam int FCS_LEN = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    DROP     = 3'd4
  } rx_state_t;

endpackage

// File: rtl/crc32_rx.sv
// Byte-wise CRC-32 step, bits taken LSB-first; the register is non-reflected,
// so a correct frame leaves CRC_RESIDUE behind.
module crc32_rx
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data_i[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                   c = {c[30:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/packet_receiver.sv
// Ethernet receive front end: SFD hunt, MAC filter, length/CRC verdict.
// Define RX_BROADCAST_EN to also accept destination FF:FF:FF:FF:FF:FF.
module packet_receiver
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_ctl,
  input  logic [47:0] mac_addr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic [15:0] out_ethertype,
  output logic        out_done,
  output logic        out_good,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [10:0] MIN_L     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L     = 11'(MAX_FRAME);
  localparam logic [10:0] HDR_LAST  = 11'(HDR_LEN - 1);
  localparam logic [2:0]  FILL_FULL = 3'(FCS_LEN);

  logic dv, er;
  assign dv = rx_ctl[0];
  assign er = rx_ctl[0] ^ rx_ctl[1];

  rx_state_t state_q, state_d;

  logic [31:0]             crc_q, crc_d, crc_nxt;
  logic [10:0]             cnt_q, cnt_d;
  logic [FCS_LEN-1:0][7:0] dly_q, dly_d;
  logic [2:0]              fill_q, fill_d;
  logic                    err_q, err_d;
  logic                    mac_ok_q, mac_ok_d;
  logic                    sof_pend_q, sof_pend_d;
  logic [15:0]             etype_q, etype_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        done_q, done_d;
  logic        good_q, good_d;
  logic [15:0] gcnt_q, gcnt_d;
  logic [15:0] bcnt_q, bcnt_d;

  logic       in_frame, sfd_hit, hdr_byte, pay_byte;
  logic       addr_phase, addr_hit_mac, addr_hit_bc, addr_bad;
  logic       emit, verdict;
  logic [7:0] mac_byte;

  assign in_frame   = (state_q == HEADER) || (state_q == PAYLOAD);
  assign sfd_hit    = (state_q == PREAMBLE) && dv && (rx_data == SFD);
  assign hdr_byte   = (state_q == HEADER) && dv;
  assign pay_byte   = (state_q == PAYLOAD) && dv;
  assign addr_phase = cnt_q < 11'd6;

  assign addr_hit_mac = mac_ok_q && (rx_data == mac_byte);
  assign addr_bad     = addr_phase && !(addr_hit_mac || addr_hit_bc);

  // Once the frame grows past MAX_FRAME nothing more is forwarded.
  assign emit = pay_byte && (fill_q == FILL_FULL) && (cnt_q < MAX_L);

  assign verdict = (crc_q == CRC_RESIDUE) && (cnt_q >= MIN_L) &&
                   (cnt_q <= MAX_L) && !err_q;

  always_comb begin
    unique case (cnt_q[2:0])
      3'd0:    mac_byte = mac_addr[47:40];
      3'd1:    mac_byte = mac_addr[39:32];
      3'd2:    mac_byte = mac_addr[31:24];
      3'd3:    mac_byte = mac_addr[23:16];
      3'd4:    mac_byte = mac_addr[15:8];
      3'd5:    mac_byte = mac_addr[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

`ifdef RX_BROADCAST_EN
  logic bc_ok_q, bc_ok_d;

  assign addr_hit_bc = bc_ok_q && (rx_data == 8'hFF);

  always_comb begin
    bc_ok_d = bc_ok_q;
    if (sfd_hit) bc_ok_d = 1'b1;
    else if (hdr_byte && addr_phase) bc_ok_d = addr_hit_bc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bc_ok_q <= 1'b0;
    else          bc_ok_q <= bc_ok_d;
  end
`else
  assign addr_hit_bc = 1'b0;
`endif

  crc32_rx u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data),
    .crc_o  (crc_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dv) state_d = (rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv)                          state_d = IDLE;
        else if (rx_data == SFD)          state_d = HEADER;
        else if (rx_data != PREAMBLE_BYTE) state_d = DROP;
      end
      HEADER: begin
        if (!dv)                    state_d = IDLE;
        else if (addr_bad)          state_d = DROP;
        else if (cnt_q == HDR_LAST) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (!dv) state_d = IDLE;
      end
      DROP: begin
        if (!dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    done_d     = 1'b0;
    good_d     = 1'b0;
    sof_pend_d = sof_pend_q;
    gcnt_d     = gcnt_q;
    bcnt_d     = bcnt_q;
    if (sfd_hit) sof_pend_d = 1'b1;
    if (emit) begin
      valid_d    = 1'b1;
      data_d     = dly_q[FCS_LEN-1];
      sof_d      = sof_pend_q;
      sof_pend_d = 1'b0;
    end
    if (in_frame && !dv) begin
      done_d = 1'b1;
      good_d = verdict;
      if (verdict) gcnt_d = gcnt_q + 16'd1;
      else         bcnt_d = bcnt_q + 16'd1;
    end
  end

  always_comb begin
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    fill_d   = fill_q;
    err_d    = err_q;
    mac_ok_d = mac_ok_q;
    etype_d  = etype_q;
    if (sfd_hit) begin
      crc_d    = CRC_INIT;
      cnt_d    = '0;
      fill_d   = '0;
      err_d    = 1'b0;
      mac_ok_d = 1'b1;
    end else if (hdr_byte || pay_byte) begin
      crc_d = crc_nxt;
      if (cnt_q != '1) cnt_d = cnt_q + 11'd1;
      if (er) err_d = 1'b1;
      if (hdr_byte) begin
        if (addr_phase) mac_ok_d = addr_hit_mac;
        if (cnt_q == 11'd12) etype_d[15:8] = rx_data;
        if (cnt_q == 11'd13) etype_d[7:0]  = rx_data;
      end else begin
        dly_d = {dly_q[FCS_LEN-2:0], rx_data};
        if (fill_q != FILL_FULL) fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q      <= CRC_INIT;
      cnt_q      <= '0;
      dly_q      <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      mac_ok_q   <= 1'b0;
      sof_pend_q <= 1'b0;
      etype_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      gcnt_q     <= '0;
      bcnt_q     <= '0;
    end else begin
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      mac_ok_q   <= mac_ok_d;
      sof_pend_q <= sof_pend_d;
      etype_q    <= etype_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      done_q     <= done_d;
      good_q     <= good_d;
      gcnt_q     <= gcnt_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_sof       = sof_q;
  assign out_ethertype = etype_q;
  assign out_done      = done_q;
  assign out_good      = good_q;
  assign good_count    = gcnt_q;
  assign bad_count     = bcnt_q;

endmodule

// File: tb/tb_packet_receiver.sv
// Randomized bench for packet_receiver with a frame-level scoreboard.
// Expected bytes/verdicts come from whole-frame rules, checked every cycle.
module tb_packet_receiver;

  localparam int MIN_F = 64;
  localparam int MAX_F = 1518;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [1:0]  rx_ctl = '0;
  logic [47:0] mac_addr = '0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_done, out_good;
  logic [15:0] out_ethertype, good_count, bad_count;

  packet_receiver #(
    .MIN_FRAME (MIN_F),
    .MAX_FRAME (MAX_F)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .rx_ctl        (rx_ctl),
    .mac_addr      (mac_addr),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_ethertype (out_ethertype),
    .out_done      (out_done),
    .out_good      (out_good),
    .good_count    (good_count),
    .bad_count     (bad_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_emit = 0;
  bit run = 1'b0;
  int m_good = 0;
  int m_bad = 0;

  logic [7:0] fr[$];

  typedef struct {
    int         due;
    logic [7:0] d;
    bit         sof;
  } em_t;

  typedef struct {
    int          due;
    bit          good;
    logic [15:0] gc;
    logic [15:0] bc;
    logic [15:0] et;
    bit          chk_et;
  } dn_t;

  em_t em_q[$];
  dn_t dn_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Textbook reflected CRC-32; returns the FCS value (complemented).
  function automatic logic [31:0] crc32(input logic [7:0] b[$], input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive(input logic [7:0] d, input bit dv, input bit e);
    rx_data = d;
    rx_ctl  = {dv ^ e, dv};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                             input int plen, input bit seq);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom));
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) fr.push_back(seq ? 8'(i) : 8'($urandom));
    c = crc32(fr, fr.size());
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  // Sends fr with preamble; predicts emitted bytes, verdict and counters.
  task automatic send_frame(input int er_idx, input int rst_at, input int gap);
    int len, last;
    bit mac_ok, bc_ok, matched, crc_ok, good, aborted;
    logic [31:0] c;
    logic [15:0] et;
    len = fr.size();
    mac_ok = 1'b1;
    bc_ok  = 1'b1;
    for (int i = 0; i < len && i < 6; i++) begin
      if (fr[i] !== mac_addr[47-8*i -: 8]) mac_ok = 1'b0;
      if (fr[i] !== 8'hFF) bc_ok = 1'b0;
    end
`ifdef RX_BROADCAST_EN
    matched = mac_ok || bc_ok;
`else
    matched = mac_ok;
`endif
    crc_ok = 1'b0;
    if (len >= 4) begin
      c = crc32(fr, len - 4);
      crc_ok = (c == {fr[len-1], fr[len-2], fr[len-3], fr[len-4]});
    end
    good = matched && crc_ok && len >= MIN_F && len <= MAX_F &&
           !(er_idx >= 0 && er_idx < len);
    last = ((len < MAX_F) ? len : MAX_F) - 5;
    et = '0;
    if (len >= 14) et = {fr[12], fr[13]};
    aborted = 1'b0;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        em_q.delete();
        dn_q.delete();
        m_good = 0;
        m_bad = 0;
        aborted = 1'b1;
      end
      if (aborted && i == rst_at + 2) reset_n = 1'b1;
      if (matched && !aborted && i >= 14 && i <= last)
        em_q.push_back('{due: cyc + 5, d: fr[i], sof: (i == 14)});
      drive(fr[i], 1'b1, i == er_idx);
    end
    if (!reset_n) reset_n = 1'b1;
    if (matched && !aborted) begin
      if (good) m_good++;
      else      m_bad++;
      dn_q.push_back('{due: cyc + 1, good: good, gc: 16'(m_good),
                       bc: 16'(m_bad), et: et, chk_et: (len >= 14)});
    end
    idle(gap);
  endtask

  always @(negedge clk) begin
    if (reset_n && run) begin
      if (em_q.size() > 0 && em_q[0].due == cyc) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, em_q[0].d);
        chk("out_sof", out_sof, em_q[0].sof);
        void'(em_q.pop_front());
      end else begin
        chk("out_valid_idle", out_valid, 0);
        chk("out_sof_idle", out_sof, 0);
      end
      if (out_valid) n_emit++;
      if (dn_q.size() > 0 && dn_q[0].due == cyc) begin
        chk("out_done", out_done, 1);
        chk("out_good", out_good, dn_q[0].good);
        chk("good_count", good_count, dn_q[0].gc);
        chk("bad_count", bad_count, dn_q[0].bc);
        if (dn_q[0].chk_et) chk("out_ethertype", out_ethertype, dn_q[0].et);
        void'(dn_q.pop_front());
      end else begin
        chk("out_done_idle", out_done, 0);
        chk("out_good_idle", out_good, 0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int e0, j;
    logic [47:0] dst;
    r = {$urandom, $urandom};
    mac_addr = {8'h02, r[39:0]};

    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    chk("crc_model_pin", crc32(fr, 9), 32'hCBF43926);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_ethertype", out_ethertype, 0);
    chk("rst_out_done", out_done, 0);
    chk("rst_out_good", out_good, 0);
    chk("rst_good_count", good_count, 0);
    chk("rst_bad_count", bad_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run = 1'b1;
    idle(2);

    build_frame(mac_addr, 16'h88B5, 46, 1'b1);
    e0 = n_emit;
    send_frame(-1, -1, 3);
    chk("t1_good_count", good_count, 1);
    chk("t1_bad_count", bad_count, 0);
    chk("t1_ethertype", out_ethertype, 16'h88B5);
    chk("t1_emitted", n_emit - e0, 46);

    fr[24] = fr[24] ^ 8'h01;
    e0 = n_emit;
    send_frame(-1, -1, 3);
    chk("t2_bad_count", bad_count, 1);
    chk("t2_good_count", good_count, 1);
    chk("t2_emitted", n_emit - e0, 46);

    fr[24] = fr[24] ^ 8'h01;
    fr[5]  = fr[5] ^ 8'h01;
    e0 = n_emit;
    send_frame(-1, -1, 3);
    chk("t3_good_count", good_count, 1);
    chk("t3_bad_count", bad_count, 1);
    chk("t3_emitted", n_emit - e0, 0);

    build_frame(mac_addr, 16'h0800, 1501, 1'b0);
    e0 = n_emit;
    send_frame(-1, -1, 3);
    chk("t4_bad_count", bad_count, 2);
    chk("t4_emitted", n_emit - e0, 1500);

    build_frame(mac_addr, 16'h0800, 42, 1'b0);
    e0 = n_emit;
    send_frame(-1, -1, 3);
    chk("t5_bad_count", bad_count, 3);
    chk("t5_emitted", n_emit - e0, 42);

    build_frame(mac_addr, 16'h0800, 46, 1'b0);
    send_frame(30, -1, 3);
    chk("t6_bad_count", bad_count, 4);

    build_frame(mac_addr, 16'h0800, 50, 1'b0);
    send_frame(-1, -1, 1);
    build_frame(mac_addr, 16'h0801, 60, 1'b0);
    send_frame(-1, -1, 3);
    chk("t7_good_count", good_count, 3);

    build_frame(mac_addr, 16'h88B5, 46, 1'b1);
    send_frame(-1, 30, 3);
    chk("t8_rst_good_count", good_count, 0);
    chk("t8_rst_bad_count", bad_count, 0);
    build_frame(mac_addr, 16'h88B5, 46, 1'b1);
    send_frame(-1, -1, 3);
    chk("t8_good_count", good_count, 1);

    build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 46, 1'b0);
    send_frame(-1, -1, 3);
`ifdef RX_BROADCAST_EN
    chk("t9_bcast_good", good_count, 2);
`else
    chk("t9_bcast_drop", good_count, 1);
`endif

    for (int t = 0; t < 30; t++) begin
      int dsel, plen, er_i, g, n, k;
      dsel = $urandom_range(0, 9);
      dst = mac_addr;
      if (dsel == 0) begin
        j = $urandom_range(0, 5);
        k = $urandom_range(0, 7);
        dst = dst ^ (48'h1 << (8 * j + k));
      end else if (dsel == 1) begin
        dst = '1;
      end
      plen = $urandom_range(40, 120);
      build_frame(dst, 16'($urandom), plen, 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(14, fr.size() - 1);
        fr[k] = fr[k] ^ 8'h10;
      end
      if ($urandom_range(0, 6) == 0) begin
        n = $urandom_range(1, 20);
        while (fr.size() > n) void'(fr.pop_back());
      end
      er_i = -1;
      if ($urandom_range(0, 7) == 0) er_i = $urandom_range(0, fr.size() - 1);
      g = $urandom_range(1, 3);
      send_frame(er_i, -1, g);
    end

    idle(10);
    chk("emit_queue_drained", em_q.size(), 0);
    chk("done_queue_drained", dn_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
